fifo_rd_stream: RTL

FIFO_RD_STREAM -- requirements
Module: fifo_rd_stream

---
 rtl/fifo_rd_stream.sv | 85 ++++++++
 1 files changed

// File: rtl/fifo_rd_stream.sv
// Converts a synchronous FIFO read port (1-cycle read latency) into a valid/ready stream
// through a 3-entry skid buffer. Optional macro FIFO_RD_STREAM_STATS_EN adds a popped-word counter.
module fifo_rd_stream #(
  parameter int DATA_WIDTH = 18
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  FIFO_EMPTY,
  output logic                  FIFO_RD_EN,
  input  logic [DATA_WIDTH-1:0] FIFO_RD_DATA,
  output logic [DATA_WIDTH-1:0] M_DATA,
  output logic                  M_VALID,
  input  logic                  M_READY,
  output logic [1:0]            LEVEL,
  output logic [15:0]           WORD_CNT
);

  if (DATA_WIDTH != 9 && DATA_WIDTH != 18) begin : g_width_check
    $fatal(1, "fifo_rd_stream: DATA_WIDTH must be 9 or 18");
  end

  logic [DATA_WIDTH-1:0] buffer_mem [3];
  logic [1:0]            wr_ptr;
  logic [1:0]            rd_ptr;
  logic [1:0]            occ;
  logic                  inflight;
  logic                  pop;

  function automatic logic [1:0] ptr_inc(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  // Reads are only issued when the word still in flight is guaranteed a free slot,
  // so the decision never depends on M_READY.
  assign FIFO_RD_EN = !RESET && !FIFO_EMPTY && (({1'b0, occ} + {2'b00, inflight}) < 3'd3);

  assign M_VALID = (occ != 2'd0);
  assign pop     = M_VALID && M_READY;
  assign LEVEL   = occ;

  always_comb begin
    M_DATA = buffer_mem[0];
    case (rd_ptr)
      2'd1:    M_DATA = buffer_mem[1];
      2'd2:    M_DATA = buffer_mem[2];
      default: M_DATA = buffer_mem[0];
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      occ      <= 2'd0;
      wr_ptr   <= 2'd0;
      rd_ptr   <= 2'd0;
      inflight <= 1'b0;
      for (int i = 0; i < 3; i++) buffer_mem[i] <= '0;
    end else begin
      inflight <= FIFO_RD_EN;
      for (int i = 0; i < 3; i++) begin
        if (inflight && wr_ptr == 2'(i)) buffer_mem[i] <= FIFO_RD_DATA;
      end
      if (inflight) wr_ptr <= ptr_inc(wr_ptr);
      if (pop) rd_ptr <= ptr_inc(rd_ptr);
      occ <= occ + {1'b0, inflight} - {1'b0, pop};
    end
  end

`ifdef FIFO_RD_STREAM_STATS_EN
  logic [15:0] word_cnt;

  // Saturates so a long-running link reads as "at least 65535" rather than wrapping.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      word_cnt <= 16'h0000;
    end else if (pop && word_cnt != 16'hFFFF) begin
      word_cnt <= word_cnt + 16'd1;
    end
  end

  assign WORD_CNT = word_cnt;
`else
  assign WORD_CNT = 16'h0000;
`endif

endmodule
